// File: rtl/pe_pkg.sv
//------------------------------------------------------------------------------
// Module : pe_pkg
// Brief  : Shared state encoding, default sizes and width helper for pe_array_v2.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pe_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ACC_W     = 32;
    localparam int DEF_LANES     = 8;
    localparam int DEF_ROWS      = 8;
    localparam int DEF_MAX_STEPS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Full-precision width of one element product.
    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe_row.sv
//------------------------------------------------------------------------------
// Module : pe_row
// Brief  : One array row: LANES multipliers, lane sum and accumulator register.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe_row
    import pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_load,
    input  logic                          i_en,
    input  logic                          i_signed,
    input  logic [ACC_W-1:0]              i_bias,
    input  logic [LANES-1:0][DATA_W-1:0]  i_ifmap,
    input  logic [LANES-1:0][DATA_W-1:0]  i_weight,
    output logic [ACC_W-1:0]              o_acc_next
);

    localparam int PW = prod_w(DATA_W);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic [PW-1:0]    w_prod [LANES];
    logic [ACC_W-1:0] w_prod_ext [LANES];

    // Operands are extended to product width first so the low PW bits of the
    // product are correct for both signed and unsigned interpretation.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [PW-1:0] w_a;
        logic [PW-1:0] w_b;
        assign w_a = {{DATA_W{i_signed & i_ifmap[l][DATA_W-1]}}, i_ifmap[l]};
        assign w_b = {{DATA_W{i_signed & i_weight[l][DATA_W-1]}}, i_weight[l]};
        assign w_prod[l]     = w_a * w_b;
        assign w_prod_ext[l] = {{(ACC_W-PW){i_signed & w_prod[l][PW-1]}}, w_prod[l]};
    end

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum = w_sum + w_prod_ext[l];
        end
    end

    always_comb begin
        o_acc_next = r_acc;
        if (i_load) begin
            o_acc_next = i_bias;
        end else if (i_en) begin
            o_acc_next = r_acc + w_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= o_acc_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_array_v2.sv
//------------------------------------------------------------------------------
// Module : pe_array_v2
// Brief  : ROWS x LANES dot-product array with bias, step handshake and output
//          backpressure. Optional ReLU on signed results via PE_ARRAY_RELU_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe_array_v2
    import pe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int LANES     = DEF_LANES,
    parameter int ROWS      = DEF_ROWS,
    parameter int MAX_STEPS = DEF_MAX_STEPS,
    parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_start,
    input  logic [STEP_W-1:0]                   i_steps,
    input  logic                                i_signed,
    input  logic [ROWS-1:0][ACC_W-1:0]          bias,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES-1:0][DATA_W-1:0]        ifmap,
    input  logic [LANES*ROWS-1:0][DATA_W-1:0]   weight,
    output logic [ROWS-1:0][ACC_W-1:0]          ofmap,
    output logic                                o_valid,
    input  logic                                o_ready,
    output logic                                busy
);

    localparam logic [STEP_W-1:0] C_MAX_STEPS = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0] C_ONE       = STEP_W'(1);

    state_t                              r_state;
    state_t                              w_state_next;
    logic [STEP_W-1:0]                   r_beats;
    logic [STEP_W-1:0]                   r_steps;
    logic [STEP_W-1:0]                   w_steps_clamped;
    logic                                r_signed;
    logic                                w_start;
    logic                                w_beat;
    logic                                w_last;
    logic                                w_mode_next;
    logic                                w_enter_out;
    logic [ROWS-1:0][ACC_W-1:0]          w_acc_next;
    logic [ROWS-1:0][ACC_W-1:0]          w_ofmap_next;
    logic [ROWS-1:0][ACC_W-1:0]          r_ofmap;
    logic [ROWS-1:0][LANES-1:0][DATA_W-1:0] w_row_weight;

    assign w_steps_clamped = (i_steps > C_MAX_STEPS) ? C_MAX_STEPS : i_steps;
    assign w_start  = i_start && ((r_state == ST_IDLE) || ((r_state == ST_OUT) && o_ready));
    assign w_beat   = (r_state == ST_ACC) && in_valid;
    assign w_last   = w_beat && ((r_beats + C_ONE) == r_steps);
    assign w_mode_next = w_start ? i_signed : r_signed;
    // A zero-step job goes straight to OUT carrying the bias as its result.
    assign w_enter_out = w_start ? (w_steps_clamped == '0) : w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = (w_steps_clamped == '0) ? ST_OUT : ST_ACC;
            ST_ACC:  if (w_last)  w_state_next = ST_OUT;
            ST_OUT: begin
                if (o_ready) begin
                    if (w_start) w_state_next = (w_steps_clamped == '0) ? ST_OUT : ST_ACC;
                    else         w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_ACC);
        o_valid  = (r_state == ST_OUT);
        busy     = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats  <= '0;
            r_steps  <= '0;
            r_signed <= 1'b0;
            r_ofmap  <= '0;
        end else begin
            if (w_start) begin
                r_beats  <= '0;
                r_steps  <= w_steps_clamped;
                r_signed <= i_signed;
            end else if (w_beat) begin
                r_beats  <= r_beats + C_ONE;
            end
            if (w_enter_out) begin
                r_ofmap <= w_ofmap_next;
            end
        end
    end

    assign ofmap = r_ofmap;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar l = 0; l < LANES; l++) begin : g_wsel
            assign w_row_weight[r][l] = weight[l*ROWS + r];
        end

        pe_row #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .LANES  (LANES)
        ) u_row (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_start),
            .i_en       (w_beat),
            .i_signed   (r_signed),
            .i_bias     (bias[r]),
            .i_ifmap    (ifmap),
            .i_weight   (w_row_weight[r]),
            .o_acc_next (w_acc_next[r])
        );

`ifdef PE_ARRAY_RELU_EN
        assign w_ofmap_next[r] = (w_mode_next && w_acc_next[r][ACC_W-1]) ? '0 : w_acc_next[r];
`else
        assign w_ofmap_next[r] = w_acc_next[r];
`endif
    end

    // Mode only matters to the ReLU path; keep it referenced in every build.
    logic w_unused;
    assign w_unused = w_mode_next;

endmodule

`default_nettype wire
